// File: rtl/multiport_register_file.sv
// Multiport integer register file with write-to-read bypass and a per-register
// busy scoreboard.
// Decode reads and allocates; writeback writes and clears busy bits.
module multiport_register_file #(
    parameter int XLEN      = 64,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = $clog2(NUM_REGS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_READ*AW-1:0]    rd_addr,
    output logic [NUM_READ*XLEN-1:0]  rd_data,
    output logic [NUM_READ-1:0]       rd_busy,
    input  logic [NUM_WRITE-1:0]      wr_en,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0] wr_data,
    input  logic                      alloc_valid,
    input  logic [AW-1:0]             alloc_addr,
    input  logic                      flush,
    output logic [CW-1:0]             busy_count
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [CW-1:0]       count_next;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Data array update; later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_en[j] && !is_zero(wr_addr[j*AW +: AW]))
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Next busy vector: flush beats everything, then write clears, then alloc sets.
    // The count is taken from the next vector so duplicate clears count once.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_en[j]) busy_next[wr_addr[j*AW +: AW]] = 1'b0;
            end
            if (alloc_valid && !is_zero(alloc_addr)) busy_next[alloc_addr] = 1'b1;
        end
        count_next = '0;
        for (int k = 0; k < NUM_REGS; k++) count_next = count_next + CW'(busy_next[k]);
    end

    // Scoreboard and its population count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    // Combinational read ports with optional forwarding from same-cycle writes;
    // a forwarded register is reported not busy because its value is present.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        rd_busy[i]              = 1'b0;
                    end
                end
            end
            if (rst || is_zero(rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: directed vector table, hand-written reset
// sequences, and random traffic against an array-based reference model.
// A second instance with BYPASS=0 shares all inputs.
module tb_multiport_register_file;

    localparam int AW = 5;
    localparam int XL = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*AW-1:0] rd_addr;
    logic [2*XL-1:0] rd_data, rd_data_nb;
    logic [1:0]     rd_busy, rd_busy_nb;
    logic [1:0]     wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*XL-1:0] wr_data;
    logic           alloc_valid;
    logic [AW-1:0]  alloc_addr;
    logic           flush;
    logic [5:0]     busy_count, busy_count_nb;

    integer n_cmp = 0;
    integer n_bad = 0;

    always #5 clk = ~clk;

    multiport_register_file dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .flush(flush), .busy_count(busy_count)
    );

    multiport_register_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .flush(flush), .busy_count(busy_count_nb)
    );

    // Reference model: architectural state as plain arrays.
    logic [63:0] m_regs [32];
    bit          m_busy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int waddr(int j);
        return int'(wr_addr[j*AW +: AW]);
    endfunction

    // Value a reader of address a should observe right now.
    function automatic logic [63:0] pred_data(int a, bit byp);
        if (rst || a == 0) return 64'h0;
        if (byp) begin
            for (int j = 1; j >= 0; j--)
                if (wr_en[j] && waddr(j) == a) return wr_data[j*XL +: XL];
        end
        return m_regs[a];
    endfunction

    function automatic logic pred_busy(int a, bit byp);
        if (rst || a == 0) return 1'b0;
        if (byp && ((wr_en[0] && waddr(0) == a) || (wr_en[1] && waddr(1) == a))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 64'h0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && waddr(j) != 0) m_regs[waddr(j)] = wr_data[j*XL +: XL];
        if (flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j]) m_busy[waddr(j)] = 1'b0;
            if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic check_reads();
        for (int i = 0; i < 2; i++) begin
            int a;
            a = int'(rd_addr[i*AW +: AW]);
            chk("rd_data_byp", rd_data[i*XL +: XL], pred_data(a, 1'b1));
            chk("rd_busy_byp", 64'(rd_busy[i]), 64'(pred_busy(a, 1'b1)));
            chk("rd_data_nobyp", rd_data_nb[i*XL +: XL], pred_data(a, 1'b0));
            chk("rd_busy_nobyp", 64'(rd_busy_nb[i]), 64'(pred_busy(a, 1'b0)));
        end
    endtask

    // One clock: check reads, take the edge, check the registered count.
    task automatic step();
        #1;
        check_reads();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_count", 64'(busy_count), 64'(m_count()));
        chk("busy_count_nb", 64'(busy_count_nb), 64'(m_count()));
    endtask

    task automatic idle_inputs();
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0; rd_addr = '0;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic rand_cycles(int n);
        for (int k = 0; k < n; k++) begin
            wr_en       = 2'($urandom_range(0, 3));
            wr_addr     = {pick_addr(), pick_addr()};
            wr_data     = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            alloc_valid = ($urandom_range(0, 1) == 1);
            alloc_addr  = pick_addr();
            flush       = ($urandom_range(0, 15) == 0);
            rd_addr     = {pick_addr(), pick_addr()};
            step();
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
        logic        av;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [63:0] d0, d1, nd0;
        logic [1:0]  b;
        logic [5:0]  cnt;
    } vec_t;

    function automatic vec_t mk(int we, int wa0, logic [63:0] wd0, int wa1, logic [63:0] wd1,
                                int av, int aa, int fl, int ra0, int ra1,
                                logic [63:0] d0, logic [63:0] d1, logic [63:0] nd0, int b, int cnt);
        vec_t v;
        v.we = 2'(we); v.wa0 = 5'(wa0); v.wd0 = wd0; v.wa1 = 5'(wa1); v.wd1 = wd1;
        v.av = 1'(av); v.aa = 5'(aa); v.fl = 1'(fl); v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.d0 = d0; v.d1 = d1; v.nd0 = nd0; v.b = 2'(b); v.cnt = 6'(cnt);
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         we   wa0 wd0            wa1 wd1       av aa fl ra0 ra1 d0             d1             nd0            b     cnt
        tbl[0]  = mk(3, 5, 64'hDEADBEEF, 6, 64'h1234, 0, 0, 0, 5, 6, 64'hDEADBEEF, 64'h1234,     64'h0,        2'b00, 0);
        tbl[1]  = mk(1, 0, 64'hFFFF,     0, 64'h0,    0, 0, 0, 0, 5, 64'h0,        64'hDEADBEEF, 64'h0,        2'b00, 0);
        tbl[2]  = mk(0, 0, 64'h0,        0, 64'h0,    0, 0, 0, 5, 6, 64'hDEADBEEF, 64'h1234,     64'hDEADBEEF, 2'b00, 0);
        tbl[3]  = mk(3, 7, 64'hAA,       7, 64'hBB,   0, 0, 0, 7, 0, 64'hBB,       64'h0,        64'h0,        2'b00, 0);
        tbl[4]  = mk(0, 0, 64'h0,        0, 64'h0,    0, 0, 0, 7, 7, 64'hBB,       64'hBB,       64'hBB,       2'b00, 0);
        tbl[5]  = mk(0, 0, 64'h0,        0, 64'h0,    1, 3, 0, 3, 4, 64'h0,        64'h0,        64'h0,        2'b00, 1);
        tbl[6]  = mk(0, 0, 64'h0,        0, 64'h0,    1, 4, 0, 3, 4, 64'h0,        64'h0,        64'h0,        2'b01, 2);
        tbl[7]  = mk(1, 3, 64'h33,       0, 64'h0,    0, 0, 0, 3, 4, 64'h33,       64'h0,        64'h0,        2'b10, 1);
        tbl[8]  = mk(1, 9, 64'h99,       0, 64'h0,    1, 9, 0, 9, 3, 64'h99,       64'h33,       64'h0,        2'b00, 2);
        tbl[9]  = mk(0, 0, 64'h0,        0, 64'h0,    1, 9, 0, 9, 4, 64'h99,       64'h0,        64'h99,       2'b11, 2);
        tbl[10] = mk(0, 0, 64'h0,        0, 64'h0,    1, 1, 0, 9, 1, 64'h99,       64'h0,        64'h99,       2'b01, 3);
        tbl[11] = mk(0, 0, 64'h0,        0, 64'h0,    1, 2, 0, 1, 2, 64'h0,        64'h0,        64'h0,        2'b01, 4);
        tbl[12] = mk(0, 0, 64'h0,        0, 64'h0,    1, 10, 0, 2, 10, 64'h0,      64'h0,        64'h0,        2'b01, 5);
        tbl[13] = mk(0, 0, 64'h0,        0, 64'h0,    1, 11, 1, 10, 11, 64'h0,     64'h0,        64'h0,        2'b01, 0);
        tbl[14] = mk(0, 0, 64'h0,        0, 64'h0,    0, 0, 0, 11, 9, 64'h0,       64'h99,       64'h0,        2'b00, 0);
        tbl[15] = mk(0, 0, 64'h0,        0, 64'h0,    0, 0, 0, 5, 7, 64'hDEADBEEF, 64'hBB,       64'hDEADBEEF, 2'b00, 0);

        // Reset held with a live write: nothing may leak through while rst is high.
        model_reset();
        idle_inputs();
        rst = 1'b1;
        wr_en = 2'b11; wr_addr = {5'd6, 5'd5};
        wr_data = {64'h1111, 64'h2222};
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        rd_addr = {5'd6, 5'd5};
        #3;
        chk("reset_rd_data0", rd_data[63:0], 64'h0);
        chk("reset_rd_data1", rd_data[127:64], 64'h0);
        chk("reset_rd_busy", 64'(rd_busy), 64'h0);
        chk("reset_busy_count", 64'(busy_count), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_hold_busy_count", 64'(busy_count), 64'h0);
        chk("reset_hold_rd_data0", rd_data[63:0], 64'h0);
        idle_inputs();
        rst = 1'b0;

        // Directed vector table.
        for (int k = 0; k < 16; k++) begin
            wr_en = tbl[k].we;
            wr_addr = {tbl[k].wa1, tbl[k].wa0};
            wr_data = {tbl[k].wd1, tbl[k].wd0};
            alloc_valid = tbl[k].av; alloc_addr = tbl[k].aa; flush = tbl[k].fl;
            rd_addr = {tbl[k].ra1, tbl[k].ra0};
            #1;
            chk($sformatf("vec%0d_d0", k), rd_data[63:0], tbl[k].d0);
            chk($sformatf("vec%0d_d1", k), rd_data[127:64], tbl[k].d1);
            chk($sformatf("vec%0d_nb_d0", k), rd_data_nb[63:0], tbl[k].nd0);
            chk($sformatf("vec%0d_busy", k), 64'(rd_busy), 64'(tbl[k].b));
            step();
            chk($sformatf("vec%0d_cnt", k), 64'(busy_count), 64'(tbl[k].cnt));
        end

        rand_cycles(400);

        // Asynchronous reset mid-cycle with state built up and a write pending.
        idle_inputs();
        alloc_valid = 1'b1; alloc_addr = 5'd12;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd13}; wr_data = {64'h0, 64'hC0FFEE};
        step();
        alloc_valid = 1'b1; alloc_addr = 5'd14;
        wr_en = 2'b11; wr_addr = {5'd13, 5'd12}; wr_data = {64'h5555, 64'h7777};
        rd_addr = {5'd13, 5'd12};
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_rd_data0", rd_data[63:0], 64'h0);
        chk("midrst_rd_data1", rd_data[127:64], 64'h0);
        chk("midrst_rd_busy", 64'(rd_busy), 64'h0);
        chk("midrst_busy_count", 64'(busy_count), 64'h0);
        chk("midrst_busy_count_nb", 64'(busy_count_nb), 64'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_cnt", 64'(busy_count), 64'h0);
        model_reset();
        idle_inputs();
        rd_addr = {5'd13, 5'd12};
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_reg12", rd_data[63:0], 64'h0);
        chk("postrst_reg13", rd_data[127:64], 64'h0);
        step();

        rand_cycles(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
Parametrised integer register file for the pipelined RV64 core. It is generalised in width, depth and read/write port count. It adds same-cycle write-to-read bypass and an integrated per-register busy scoreboard with flush. The block sits between decode (reads and allocation) and writeback (writes and busy clear), and replaces the single-write 2-read file.

Parameters:
XLEN, 64, data width of each register.
NUM_REGS, 32, number of architectural registers (power of 2, >= 2); AW = $clog2(NUM_REGS).
NUM_READ, 2, number of combinational read ports (>= 1).
NUM_WRITE, 2, number of write ports (>= 1).
BYPASS, 1, 1 = reads see same-cycle write data and busy clear; 0 = reads see state as of the last clock edge.
ZERO_REG, 1, 1 = register 0 is hard-wired to zero and never busy.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
rd_addr  in  NUM_READ*AW  read addresses; port i occupies [i*AW +: AW].
rd_data  out  NUM_READ*XLEN  read data; port i occupies [i*XLEN +: XLEN].
rd_busy  out  NUM_READ  busy flag for each read port's register.
wr_en  in  NUM_WRITE  per-port write enable.
wr_addr  in  NUM_WRITE*AW  write addresses.
wr_data  in  NUM_WRITE*XLEN  write data.
alloc_valid  in  1  mark register alloc_addr busy (new in-flight producer).
alloc_addr  in  AW  register to mark busy.
flush  in  1  synchronous clear of all busy bits (pipeline flush); data is unaffected.
busy_count  out  $clog2(NUM_REGS+1)  registered count of busy registers.

Behaviour:
- Reset (async, rst=1):
  - All registers = 0; all busy bits = 0; busy_count = 0.
  - rd_data reads 0 and rd_busy reads 0 for every address while rst is high.
  - Reset asserted mid-operation discards pending writes and allocations immediately.
- Write, on the rising edge:
  - For each port j with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
  - Same address on several enabled ports: the highest-index port wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read, combinational, zero latency:
  - rd_data[i] = reg[rd_addr[i]].
  - If BYPASS=1 and any enabled write port targets rd_addr[i], forward wr_data from the highest-index matching port instead.
  - With ZERO_REG=1, address 0 always reads 0 and is never forwarded.
- Scoreboard, one busy bit per register, updated on the rising edge in this priority order:
  1. flush=1: all busy bits <= 0; alloc_valid is ignored that cycle; writes still update data.
  2. Otherwise, a write on any port clears busy[wr_addr[j]].
  3. alloc_valid sets busy[alloc_addr]. If alloc_addr equals a same-cycle write address, alloc wins and the bit ends at 1 (newer producer).
  4. With ZERO_REG=1, alloc of address 0 is ignored.
  5. Allocating an already-busy register leaves it busy (no error, no count change).
- rd_busy[i]:
  - Equals busy[rd_addr[i]].
  - With BYPASS=1 it is forced to 0 if an enabled same-cycle write targets that address, since the data is forwarded.
  - A same-cycle alloc is not visible until the next cycle.
- busy_count:
  - Registered; equals the popcount of the busy vector after the edge.
  - Maintained incrementally (+1 for a newly set bit, -1 per distinctly cleared bit) or recomputed; it must never under- or overflow.
  - Reads 0 in the cycle after a flush.
- Multiple write ports clearing the same busy bit count as a single clear.

Test Plan:
1. Reset, then write port0 reg5=0xDEAD_BEEF and port1 reg6=0x1234 in one cycle -> next cycle rd_addr={5,6} returns 0xDEADBEEF and 0x1234; register 0 still reads 0 after wr_en to addr 0 with 0xFFFF.
2. Both write ports target reg7 (port0=0xAA, port1=0xBB) while port0 reads reg7, BYPASS=1 -> same-cycle rd_data=0xBB, and 0xBB is stored. With BYPASS=0 the same-cycle read returns the old value 0.
3. alloc reg3, then reg4 on the next cycle -> busy_count 1, then 2; rd_busy for reg3=1. A write to reg3 clears it: with BYPASS=1 rd_busy=0 during the write cycle, and busy_count=1 after.
4. alloc reg9 and write reg9 in the same cycle -> reg9 data updated, busy stays 1, busy_count +1. Allocating an already-busy reg9 leaves busy_count unchanged.
5. Allocate reg1, reg2 and reg10, then assert flush with alloc_valid of reg11 -> all rd_busy=0, busy_count=0, reg11 not busy, register data unchanged.
6. Assert rst asynchronously mid-cycle after several writes and allocs -> rd_data=0 immediately, busy_count=0, all busy bits 0; normal operation resumes after deassert.
